bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter: accepts a packed multi-digit BCD value and returns its binary equivalent via iterative reverse double-dabble, one shift per clock. It is the inverse of the game controller's binary-to-BCD score path. It converts BCD-entered values, such as keypad digits or stored high-score digits, back into binary for comparison against the binary `distance_drove` count. It is a start/done handshaked block, clocked in the game clock domain.

---
 rtl/game_pkg.sv | 22 ++
 rtl/bcd_to_bin_seq_if.sv | 37 +++
 rtl/bcd_nibble_adj.sv | 19 +
 rtl/bcd_to_bin_seq.sv | 160 ++++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : game_pkg
// Purpose: Types and constants shared by the game controller's score paths
//          (binary-to-BCD and BCD-to-binary).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package game_pkg;

   // Score width constants, shared with the binary-to-BCD path
   localparam int SCORE_DIGITS = 3;
   localparam int SCORE_BIN_W  = 10;

   // BCD-to-binary converter sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd2bin_state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/bcd_to_bin_seq_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : bcd_to_bin_seq_if
// Purpose: Start/done handshake bundle for the BCD-to-binary converter.
// Ports  : start   - request pulse (master -> slave)
//          bcd_in  - packed BCD operand, digit 0 in [3:0] (master -> slave)
//          busy    - conversion in flight (slave -> master)
//          done    - one-cycle result strobe (slave -> master)
//          err     - invalid BCD nibble seen, valid with done (slave -> master)
//          bin_out - binary result (slave -> master)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
interface bcd_to_bin_seq_if
   import game_pkg::*;
#(
   parameter int DIGITS = SCORE_DIGITS,
   parameter int BIN_W  = SCORE_BIN_W
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [BIN_W-1:0]      bin_out;

   modport master (
      output start, bcd_in,
      input  busy, done, err, bin_out
   );

   modport slave (
      input  start, bcd_in,
      output busy, done, err, bin_out
   );

endinterface : bcd_to_bin_seq_if
`default_nettype wire

// File: rtl/bcd_nibble_adj.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : bcd_nibble_adj
// Purpose: Reverse double-dabble digit correction. After a right shift a
//          nibble that reads 8 or more has picked up a weight-10 bit from the
//          digit above as 8; subtracting 3 restores its decimal weight of 5.
// Ports  : i_nib - shifted BCD nibble
//          o_nib - corrected nibble
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module bcd_nibble_adj (
   input  wire logic [3:0] i_nib,
   output logic      [3:0] o_nib
);

   assign o_nib = i_nib[3] ? (i_nib - 4'd3) : i_nib;

endmodule : bcd_nibble_adj
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : bcd_to_bin_seq
// Purpose: Sequential BCD-to-binary converter using iterative reverse
//          double-dabble, one shift per clock. Converts keypad or stored
//          high-score digits back to binary for distance comparison.
// Ports  : clk    - game clock, rising edge
//          resetN - asynchronous active-low reset
//          bus    - bcd_to_bin_seq_if.slave handshake
//                   (start, bcd_in, busy, done, err, bin_out)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module bcd_to_bin_seq
   import game_pkg::*;
#(
   parameter int DIGITS = SCORE_DIGITS,
   parameter int BIN_W  = SCORE_BIN_W
) (
   input  wire logic       clk,
   input  wire logic       resetN,
   bcd_to_bin_seq_if.slave bus
);

   localparam int                BCD_W    = 4 * DIGITS;
   localparam int                CNT_W    = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);

   bcd2bin_state_t     r_state;
   bcd2bin_state_t     w_state_nxt;
   logic               w_accept;
   logic               w_bad;

   logic [CNT_W-1:0]   r_cnt;
   logic [BCD_W-1:0]   r_bcd;        // bcd half of the work register W
   logic [BIN_W-1:0]   r_bin;        // binary half of the work register W
   logic               r_err_flag;   // request had an invalid nibble
   logic               r_done;
   logic               r_err;
   logic [BIN_W-1:0]   r_bin_out;

   logic [BCD_W-1:0]   w_bcd_sh;
   logic [BCD_W-1:0]   w_bcd_adj;
   logic [BIN_W-1:0]   w_bin_sh;

   //---------------------------------------------------------------------------
   // Input validation: any nibble above 9 flags the request as bad
   //---------------------------------------------------------------------------
   always_comb begin
      w_bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bus.bcd_in[4*d +: 4] > 4'd9) begin
            w_bad = 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Shift datapath: W >> 1, the bcd LSB falls into the bin MSB, then every
   // bcd nibble is corrected independently.
   //---------------------------------------------------------------------------
   assign w_bcd_sh = r_bcd >> 1;
   assign w_bin_sh = {r_bcd[0], r_bin[BIN_W-1:1]};

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib_adj
      bcd_nibble_adj u_adj (
         .i_nib (w_bcd_sh[4*gi +: 4]),
         .o_nib (w_bcd_adj[4*gi +: 4])
      );
   end

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // FSM: next state
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               // Invalid operands skip shifting entirely
               w_state_nxt = w_bad ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Work register, counter and result registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_cnt      <= '0;
         r_bcd      <= '0;
         r_bin      <= '0;
         r_err_flag <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_bin_out  <= '0;
      end else begin
         // done is registered off the DONE state, so it lands in the first
         // IDLE cycle and a held start can be accepted alongside it
         r_done <= (r_state == DONE);

         if (w_accept) begin
            r_bcd      <= bus.bcd_in;
            r_bin      <= '0;
            r_cnt      <= '0;
            r_err_flag <= w_bad;
            r_err      <= 1'b0;
         end

         if (r_state == SHIFT) begin
            r_bcd <= w_bcd_adj;
            r_bin <= w_bin_sh;
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if (r_state == DONE) begin
            r_bin_out <= r_err_flag ? '0 : r_bin;
            r_err     <= r_err_flag;
         end
      end
   end

   assign bus.busy    = (r_state != IDLE);
   assign bus.done    = r_done;
   assign bus.err     = r_err;
   assign bus.bin_out = r_bin_out;

   // A valid operand is fully drained into the binary half after BIN_W shifts
   a_bcd_drained : assert property (
      @(posedge clk) disable iff (!resetN)
      (r_state == DONE && !r_err_flag) |-> (r_bcd == '0)
   );

endmodule : bcd_to_bin_seq
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_bcd_to_bin_seq
// Purpose: Self-checking bench for bcd_to_bin_seq. A transaction-level model
//          predicts busy/done/err/bin_out each cycle; directed scenarios add
//          literal expectations.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_bcd_to_bin_seq;
   import game_pkg::*;

   localparam int DIGITS = SCORE_DIGITS;
   localparam int BIN_W  = SCORE_BIN_W;
   localparam int BCD_W  = 4 * DIGITS;

   logic clk = 1'b0;
   logic resetN;
   bit   chk_en = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

   bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int bcd_value(input logic [BCD_W-1:0] v);
      int r = 0;
      for (int d = DIGITS - 1; d >= 0; d--) r = r * 10 + int'(v[4*d +: 4]);
      return r;
   endfunction

   function automatic bit bcd_invalid(input logic [BCD_W-1:0] v);
      bit b = 1'b0;
      for (int d = 0; d < DIGITS; d++) if (int'(v[4*d +: 4]) > 9) b = 1'b1;
      return b;
   endfunction

   //---------------------------------------------------------------------------
   // Transaction model: a request occupies the block for BIN_W+1 cycles
   // (valid) or 1 cycle (invalid); done/result appear when that time expires.
   //---------------------------------------------------------------------------
   int m_timer, m_res, m_bin;
   bit m_res_err, m_err, m_done;

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_timer = 0; m_res = 0; m_res_err = 0;
         m_bin = 0; m_err = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (m_timer == 0) begin
            if (bus.start) begin
               m_err = 0;
               if (bcd_invalid(bus.bcd_in)) begin
                  m_res_err = 1; m_res = 0; m_timer = 1;
               end else begin
                  m_res_err = 0; m_res = bcd_value(bus.bcd_in); m_timer = BIN_W + 1;
               end
            end
         end else begin
            m_timer--;
            if (m_timer == 0) begin
               m_done = 1; m_bin = m_res; m_err = m_res_err;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",    int'(bus.busy),    int'(m_timer != 0));
         check("done",    int'(bus.done),    int'(m_done));
         check("err",     int'(bus.err),     int'(m_err));
         check("bin_out", int'(bus.bin_out), m_bin);
      end
   end

   //---------------------------------------------------------------------------
   // Directed helpers (called at posedge+1)
   //---------------------------------------------------------------------------
   task automatic run_conv(input logic [BCD_W-1:0] code, input int exp_bin,
                           input int exp_err, input int exp_lat, input string tag);
      int lat  = 0;
      bit seen = 1'b0;
      bus.start  = 1'b1;
      bus.bcd_in = code;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.bcd_in = ~code;             // post-acceptance changes must not matter
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin seen = 1'b1; lat = k; end
      end
      check({tag, " done_seen"}, int'(seen), 1);
      check({tag, " latency"},   lat, exp_lat);
      check({tag, " bin_out"},   int'(bus.bin_out), exp_bin);
      check({tag, " err"},       int'(bus.err), exp_err);
   endtask

   task automatic count_dones(input int cycles, output int n, output int last_bin);
      n = 0; last_bin = -1;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin n++; last_bin = int'(bus.bin_out); end
      end
   endtask

   initial begin
      int n_done, got_bin, prev, pulses;
      logic [BCD_W-1:0] code;

      resetN     = 1'b1;
      bus.start  = 1'b0;
      bus.bcd_in = '0;
      #2 resetN  = 1'b0;
      chk_en     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy",    int'(bus.busy), 0);
      check("reset done",    int'(bus.done), 0);
      check("reset err",     int'(bus.err), 0);
      check("reset bin_out", int'(bus.bin_out), 0);
      resetN = 1'b1;
      @(posedge clk); #1;

      // Basic conversions
      run_conv(12'h999, 999, 0, 11, "c999");
      run_conv(12'h000,   0, 0, 11, "c000");
      run_conv(12'h105, 105, 0, 11, "c105");

      // Invalid nibbles
      run_conv(12'h1A3, 0, 1, 1, "bad1A3");
      run_conv(12'hF00, 0, 1, 1, "badF00");
      run_conv(12'h00A, 0, 1, 1, "bad00A");
      run_conv(12'h009,   9, 0, 11, "c009");   // err must clear

      // start during a conversion is ignored
      bus.start = 1'b1; bus.bcd_in = 12'h042;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.bcd_in = 12'h777;
      @(posedge clk); #1;
      bus.start = 1'b0;
      count_dones(30, n_done, got_bin);
      check("ignore n_done", n_done, 1);
      check("ignore bin",    got_bin, 42);
      run_conv(12'h777, 777, 0, 11, "c777");

      // start held high: one result every BIN_W+2 cycles
      bus.start = 1'b1; bus.bcd_in = 12'h500;
      prev = 0; pulses = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            check("held spacing", k - prev, (pulses == 0) ? 12 : BIN_W + 2);
            check("held bin", int'(bus.bin_out), 500);
            prev = k;
            pulses++;
         end
      end
      check("held pulses", pulses, 3);
      bus.start = 1'b0;
      repeat (15) @(posedge clk);
      #1;

      // Reset mid-conversion
      bus.start = 1'b1; bus.bcd_in = 12'h999;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      resetN = 1'b0;
      #1;
      check("abort busy",    int'(bus.busy), 0);
      check("abort done",    int'(bus.done), 0);
      check("abort err",     int'(bus.err), 0);
      check("abort bin_out", int'(bus.bin_out), 0);
      @(posedge clk); #1;
      resetN = 1'b1;
      count_dones(20, n_done, got_bin);
      check("abort no_done", n_done, 0);
      run_conv(12'h321, 321, 0, 11, "c321");

      // Exhaustive sweep of valid codes
      for (int v = 0; v < 1000; v++) begin
         code = '0;
         code[3:0]  = 4'(v % 10);
         code[7:4]  = 4'((v / 10) % 10);
         code[11:8] = 4'(v / 100);
         run_conv(code, v, 0, 11, "sweep");
      end

      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_bcd_to_bin_seq
`default_nettype wire
